pixel_writer: RTL and testbench
===============================

Name: pixel_writer

Overview:
- Sits directly downstream of the 160x120 pixel-sweep generator. Consumes its X/Y coordinate and 12-bit color stream and turns it into framebuffer write transactions.
- Buffers pixels in a small FIFO with a valid/ready input handshake.
- Filters out-of-range coordinates.
- Computes the linear address y*160+x in a 2-stage pipeline that honours a framebuffer stall.

Parameters:
- H_RES, 160, pixels per row; x valid range 0..H_RES-1
- V_RES, 120, rows per frame; y valid range 0..V_RES-1
- COLOR_W, 12, color width in bits
- ADDR_W, 15, framebuffer address width (19200 locations)
- DEPTH, 4, FIFO entries; power of two, minimum 2

Ports:
- clk  in  1  system clock; all logic on the rising edge
- resetn  in  1  synchronous reset, active-low
- in_x  in  8  pixel column
- in_y  in  8  pixel row
- in_color  in  COLOR_W  pixel color
- in_valid  in  1  pixel offered
- in_ready  out  1  1 = FIFO can accept; equals (count < DEPTH), driven from registered count
- fb_stall  in  1  framebuffer write port busy this cycle
- wr_en  out  1  framebuffer write strobe, registered
- wr_addr  out  ADDR_W  framebuffer address, registered
- wr_data  out  COLOR_W  framebuffer data, registered
- busy  out  1  any pixel held in FIFO, stage 1, or wr_en
- drop_count  out  8  saturating count of rejected out-of-range pixels

Behaviour:
- Reset (resetn=0 at an edge):
  - FIFO count=0, pointers=0, s1_valid=0.
  - wr_en=0, wr_addr=0, wr_data=0, drop_count=0.
  - in_ready therefore 1 after reset; busy=0.
  - Reset mid-operation discards all buffered pixels with no partial write.
- Accept:
  - A transfer occurs at an edge with in_valid & in_ready.
  - If in_x>=H_RES or in_y>=V_RES, the pixel is consumed but not stored, and drop_count increments (saturates at 255).
  - Otherwise the pixel is pushed into the FIFO.
- Pop: at an edge with count>0, !fb_stall, and stage 1 able to advance, the head is loaded into stage 1:
  - s1_valid=1
  - s1_base = y*160, computed as (y<<7)+(y<<5), no multiplier
  - s1_x and s1_color captured
- Stage 2, at an edge with !fb_stall:
  - wr_en <= s1_valid
  - wr_addr <= s1_base + s1_x, truncated to ADDR_W; maximum 19199 fits
  - wr_data <= s1_color
  - s1_valid is cleared if no new pop occurs.
- Stall (fb_stall=1 at an edge):
  - No pop; stage 1 holds.
  - wr_en <= 0; wr_addr and wr_data hold.
  - No write is lost or duplicated.
- Latency: a pixel accepted into an empty FIFO at edge k, with no stall, produces wr_en=1 after edge k+2.
- Throughput: 1 pixel/cycle sustained with no stall.
- FIFO boundaries:
  - Simultaneous push and pop leaves count unchanged.
  - Full (count=DEPTH) gives in_ready=0; no push, even if a pop occurs on the same edge.
  - Empty gives no pop and s1_valid clears.
  - Pointers wrap modulo DEPTH.
- Ordering: writes are issued strictly in acceptance order.

Decomposition:
- Shared package pixel_pkg holds:
  - H_RES, V_RES, COLOR_W, ADDR_W
  - X_MAX=159, Y_MAX=119
  - a function coord_to_addr(x,y) returning (y<<7)+(y<<5)+x, for reuse by the scanout side.
- One sub-module, pixel_fifo:
  - Synchronous FIFO of {x,y,color} entries, with push, pop, full, empty and count.
  - Same clk/resetn.

Test Plan:
- Reset: hold resetn=0 for 3 cycles, then release -> in_ready=1, wr_en=0, busy=0, drop_count=0.
- Single pixel: x=5, y=2, color=12'hF0F, one-cycle valid at edge k -> wr_en=1 after edge k+2 only, wr_addr=325, wr_data=12'hF0F.
- Corner sweep: x=159, y=119 -> wr_addr=19199. Then x=0, y=0 -> wr_addr=0, and the order is preserved.
- Out-of-range: x=160, y=0, then x=0, y=120 -> no wr_en, drop_count=2. Force 300 drops -> drop_count=255.
- Stall/backpressure:
  - Hold fb_stall=1 and stream 6 pixels -> in_ready falls to 0 after 4 are accepted while stage 1 holds; wr_en stays 0 throughout.
  - Release fb_stall -> all accepted pixels are written in order, one per cycle, and in_ready returns to 1.
- Reset mid-stream: assert resetn=0 with 3 pixels buffered -> the next cycle shows wr_en=0, busy=0, and no buffered pixel is ever written.

Source files
------------

// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared geometry, pixel entry type and address helper
package pixel_pkg;

  localparam int H_RES   = 160;
  localparam int V_RES   = 120;
  localparam int COLOR_W = 12;
  localparam int ADDR_W  = 15;
  localparam int X_MAX   = H_RES - 1;
  localparam int Y_MAX   = V_RES - 1;

  typedef struct packed {
    logic [7:0]         x;
    logic [7:0]         y;
    logic [COLOR_W-1:0] color;
  } pixel_t;

  // y*160 + x built from shifts so no multiplier is inferred
  function automatic logic [ADDR_W-1:0] coord_to_addr(input logic [7:0] x, input logic [7:0] y);
    logic [ADDR_W-1:0] y_ext;
    y_ext = ADDR_W'(y);
    return (y_ext << 7) + (y_ext << 5) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - synchronous FIFO of pixel entries with count
module pixel_fifo
  import pixel_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push_i,
  input  pixel_t                   wdata_i,
  input  logic                     pop_i,
  output pixel_t                   rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  pixel_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Power-of-two depth lets the pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/pixel_writer.sv
// rtl/pixel_writer.sv - range filter, pixel FIFO and 2-stage address pipeline to framebuffer
module pixel_writer
  import pixel_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [7:0]         in_x,
  input  logic [7:0]         in_y,
  input  logic [COLOR_W-1:0] in_color,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               fb_stall,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [COLOR_W-1:0] wr_data,
  output logic               busy,
  output logic [7:0]         drop_count
);

  logic                   fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  pixel_t                 fifo_head, fifo_wdata;
  logic                   accept, in_range, push, pop;

  logic                   s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0]      s1_base_q, s1_base_d;
  logic [7:0]             s1_x_q, s1_x_d;
  logic [COLOR_W-1:0]     s1_color_q, s1_color_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [COLOR_W-1:0]     wr_data_q, wr_data_d;
  logic [7:0]             drop_q, drop_d;
  logic [ADDR_W-1:0]      head_y_ext;

  assign in_ready = ~fifo_full;
  assign accept   = in_valid & in_ready;
  assign in_range = (in_x <= 8'(X_MAX)) & (in_y <= 8'(Y_MAX));
  assign push     = accept & in_range;
  // Stage 1 always drains into stage 2 when not stalled, so only the stall gates the pop
  assign pop      = ~fifo_empty & ~fb_stall;

  assign fifo_wdata = '{x: in_x, y: in_y, color: in_color};

  pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head_y_ext = ADDR_W'(fifo_head.y);

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_base_d  = s1_base_q;
    s1_x_d     = s1_x_q;
    s1_color_d = s1_color_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    drop_d     = drop_q;

    if (!fb_stall) begin
      s1_valid_d = pop;
      if (pop) begin
        s1_base_d  = (head_y_ext << 7) + (head_y_ext << 5);
        s1_x_d     = fifo_head.x;
        s1_color_d = fifo_head.color;
      end
      wr_en_d   = s1_valid_q;
      wr_addr_d = s1_base_q + ADDR_W'(s1_x_q);
      wr_data_d = s1_color_q;
    end

    if (accept && !in_range && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_base_q  <= '0;
      s1_x_q     <= '0;
      s1_color_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      drop_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_base_q  <= s1_base_d;
      s1_x_q     <= s1_x_d;
      s1_color_q <= s1_color_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      drop_q     <= drop_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign drop_count = drop_q;
  assign busy       = (fifo_count != '0) | s1_valid_q | wr_en_q;

endmodule

// File: tb/tb_pixel_writer.sv
// tb/tb_pixel_writer.sv - randomized self-checking bench for pixel_writer
module tb_pixel_writer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  in_x = '0;
  logic [7:0]  in_y = '0;
  logic [11:0] in_color = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        fb_stall = 1'b0;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [11:0] wr_data;
  logic        busy;
  logic [7:0]  drop_count;

  pixel_writer dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_color   (in_color),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fb_stall   (fb_stall),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
  } exp_t;

  exp_t exp_q[$];
  int   wr_log[$];
  int   wr_cyc[$];
  int   drops = 0;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  task automatic set_px(input int x, input int y, input int c);
    in_x     = 8'(x);
    in_y     = 8'(y);
    in_color = 12'(c);
  endtask

  // One clock: record handshake before the edge, update the reference after it, then score outputs
  task automatic step();
    bit   acc, stl, rst;
    int   x, y, c;
    exp_t e;
    acc = in_valid && in_ready && resetn;
    stl = fb_stall;
    rst = !resetn;
    x = int'(in_x);
    y = int'(in_y);
    c = int'(in_color);
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      exp_q.delete();
      drops = 0;
    end else if (acc) begin
      if (x < 160 && y < 120) begin
        e.addr = y * 160 + x;
        e.data = c;
        exp_q.push_back(e);
      end else if (drops < 255) begin
        drops++;
      end
    end
    if (stl || rst) chk_eq("no_write_when_stalled_or_reset", 32'(wr_en), 0);
    if (wr_en === 1'b1) begin
      wr_log.push_back(int'(wr_addr));
      wr_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk_eq("write_was_expected", 32'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        chk_eq("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk_eq("wr_data", 32'(wr_data), 32'(e.data));
      end
    end
    chk_eq("drop_count", 32'(drop_count), 32'(drops));
  endtask

  initial begin
    int idx;
    bit acc_now;
    int sx[6], sy[6], sc[6];

    // Reset
    resetn = 1'b0;
    repeat (3) step();
    resetn = 1'b1;
    chk_eq("rst_in_ready", 32'(in_ready), 1);
    chk_eq("rst_wr_en", 32'(wr_en), 0);
    chk_eq("rst_busy", 32'(busy), 0);
    chk_eq("rst_drop", 32'(drop_count), 0);

    // Single pixel latency
    set_px(5, 2, 12'hF0F);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk_eq("lat_k_wr_en", 32'(wr_en), 0);
    step();
    chk_eq("lat_k1_wr_en", 32'(wr_en), 0);
    step();
    chk_eq("lat_k2_wr_en", 32'(wr_en), 1);
    chk_eq("lat_k2_addr", 32'(wr_addr), 325);
    chk_eq("lat_k2_data", 32'(wr_data), 32'h0F0F);
    step();
    chk_eq("lat_k3_wr_en", 32'(wr_en), 0);

    // Corner sweep and ordering
    wr_log.delete();
    in_valid = 1'b1;
    set_px(159, 119, 12'h123);
    step();
    set_px(0, 0, 12'hABC);
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk_eq("corner_count", 32'(wr_log.size()), 2);
    if (wr_log.size() == 2) begin
      chk_eq("corner_max_addr", 32'(wr_log[0]), 19199);
      chk_eq("corner_zero_addr", 32'(wr_log[1]), 0);
    end

    // Out-of-range filtering and drop saturation
    wr_log.delete();
    in_valid = 1'b1;
    set_px(160, 0, 12'h111);
    step();
    set_px(0, 120, 12'h222);
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk_eq("oor_no_write", 32'(wr_log.size()), 0);
    chk_eq("oor_drop2", 32'(drop_count), 2);
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      set_px($urandom_range(160, 255), $urandom_range(0, 255), $urandom);
      step();
    end
    in_valid = 1'b0;
    step();
    chk_eq("drop_saturated", 32'(drop_count), 255);

    // Stall / backpressure
    for (int i = 0; i < 6; i++) begin
      sx[i] = $urandom_range(0, 159);
      sy[i] = $urandom_range(0, 119);
      sc[i] = $urandom_range(0, 4095);
    end
    wr_log.delete();
    wr_cyc.delete();
    fb_stall = 1'b1;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = (idx < 6);
      if (idx < 6) set_px(sx[idx], sy[idx], sc[idx]);
      acc_now = in_valid && in_ready;
      step();
      if (acc_now) idx++;
    end
    chk_eq("stall_accepted", 32'(idx), 4);
    chk_eq("stall_in_ready", 32'(in_ready), 0);
    chk_eq("stall_busy", 32'(busy), 1);
    chk_eq("stall_no_writes", 32'(wr_log.size()), 0);
    fb_stall = 1'b0;
    for (int c = 0; c < 12; c++) begin
      in_valid = (idx < 6);
      if (idx < 6) set_px(sx[idx], sy[idx], sc[idx]);
      acc_now = in_valid && in_ready;
      step();
      if (acc_now) idx++;
    end
    in_valid = 1'b0;
    chk_eq("release_all_accepted", 32'(idx), 6);
    chk_eq("release_writes", 32'(wr_log.size()), 6);
    chk_eq("release_in_ready", 32'(in_ready), 1);
    for (int i = 1; i < wr_cyc.size(); i++)
      chk_eq("release_back_to_back", 32'(wr_cyc[i] - wr_cyc[i-1]), 1);

    // Reset with pixels buffered
    fb_stall = 1'b1;
    idx = 0;
    for (int c = 0; c < 6 && idx < 3; c++) begin
      in_valid = 1'b1;
      set_px($urandom_range(0, 159), $urandom_range(0, 119), $urandom);
      acc_now = in_ready;
      step();
      if (acc_now) idx++;
    end
    in_valid = 1'b0;
    chk_eq("midrst_buffered", 32'(idx), 3);
    resetn = 1'b0;
    step();
    chk_eq("midrst_wr_en", 32'(wr_en), 0);
    chk_eq("midrst_busy", 32'(busy), 0);
    resetn = 1'b1;
    fb_stall = 1'b0;
    wr_log.delete();
    repeat (8) step();
    chk_eq("midrst_no_leak", 32'(wr_log.size()), 0);

    // Random traffic against the scoreboard
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      set_px($urandom_range(0, 170), $urandom_range(0, 127), $urandom);
      fb_stall = ($urandom_range(0, 3) == 0);
      step();
    end
    in_valid = 1'b0;
    fb_stall = 1'b0;
    repeat (8) step();
    chk_eq("drain_empty", 32'(exp_q.size()), 0);
    chk_eq("drain_busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
